decoder_nx_scan: RTL and testbench
==================================

DECODER_NX_SCAN -- requirements
Module: decoder_nx_scan

Interface
REQ-001 The block SHALL have parameter N, default 2: select width; output width is 2**N; legal range 1..6.
REQ-002 The block SHALL have parameter DWELL, default 4: cycles each output stays asserted in scan mode; legal range 1..256.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: global enable; 0 forces IDLE.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = direct decode, 1 = auto-scan.
REQ-007 The block SHALL have port i, input, N bits: select value in direct mode; start index for load in scan mode.
REQ-008 The block SHALL have port load, input, 1 bit: in SCAN, jump the scan index to i.
REQ-009 The block SHALL have port d, output, 2**N bits: registered one-hot decode output.
REQ-010 The block SHALL have port idx, output, N bits: index currently driven on d.
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the scan index wraps from 2**N-1 to 0.

Function
REQ-012 The block SHALL implement a three-state machine: IDLE, DIRECT, SCAN.
REQ-013 The FSM SHALL transition on every edge as follows: en=0 -> IDLE; en=1 and mode=0 -> DIRECT; en=1 and mode=1 -> SCAN.
REQ-014 In IDLE: d=0, idx holds its last value, wrap=0, dwell counter=0.
REQ-015 In DIRECT: d = one-hot(i) registered, so d reflects i sampled one cycle earlier (latency 1); idx = registered i; wrap=0.
REQ-016 In DIRECT: load SHALL be ignored.
REQ-017 Entering SCAN from IDLE or DIRECT: idx <= 0, dwell <= 0, d <= one-hot(0) on the same edge.
REQ-018 In SCAN: dwell SHALL count 0..DWELL-1; at DWELL-1, idx advances by 1 modulo 2**N and dwell returns to 0.
REQ-019 In SCAN: d SHALL be one-hot(idx) at all times, with exactly one bit set.
REQ-020 wrap SHALL be 1 for exactly the cycle following the edge on which idx advances from 2**N-1 to 0, and 0 otherwise.
REQ-021 In SCAN with load=1: idx <= i and dwell <= 0 on that edge; load takes priority over a simultaneous advance; load never raises wrap.
REQ-022 With DWELL=1: idx SHALL advance every cycle while in SCAN.
REQ-023 mode change SCAN -> DIRECT mid-dwell: the scan is abandoned; the next edge produces the direct decode of i; dwell is cleared.
REQ-024 en falling mid-operation: d=0 on the next edge; re-enabling into SCAN restarts at idx=0.
REQ-025 The dwell counter width SHALL be ceil(log2(DWELL)), minimum 1; idx increment SHALL wrap naturally within N bits.
REQ-026 Outputs SHALL be driven only from registers, with no combinational path from inputs to d, idx or wrap.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force: state=IDLE, d=0, idx=0, wrap=0, dwell=0.
REQ-028 Release of rst_n SHALL take effect on the first rising clk edge with rst_n=1.
REQ-029 Reset asserted mid-scan SHALL discard the scan position; after release, SCAN restarts from idx=0.

Verification
REQ-030 Scenario, direct decode (N=2, en=1, mode=0): i=00,01,10,11 on consecutive cycles -> d=0001,0010,0100,1000, each one cycle later.
REQ-031 Scenario, scan wrap (N=2, DWELL=4, mode=1): run 16 cycles -> idx sequence 0,1,2,3, each held 4 cycles; wrap pulses once, on the cycle idx returns to 0.
REQ-032 Scenario, load: during SCAN with idx=1, pulse load with i=3 -> next cycle idx=3, d=1000; dwell restarts, so idx stays 3 for 4 cycles; wrap=0 on the load cycle.
REQ-033 Scenario, load coinciding with an advance: load on the edge where dwell=DWELL-1 -> idx=i, not idx+1.
REQ-034 Scenario, async reset: assert rst_n=0 between clock edges while d=0100 -> d=0000 and idx=0 before the next edge; after release with mode=1, scan begins at d=0001.
REQ-035 Scenario, parameter sweep (N=3, DWELL=1): SCAN -> d walks 00000001 through 10000000 in 8 cycles; wrap pulses every 8th cycle; d is one-hot on every cycle.

Source files
------------

// File: rtl/decoder_nx_scan.sv
// N-to-2**N one-hot decoder with a direct mode and an auto-scan mode.
// Every output (d, idx, wrap) comes straight from a register.
module decoder_nx_scan #(
    parameter int unsigned N     = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     i,
    input  logic             load,
    output logic [2**N-1:0]  d,
    output logic [N-1:0]     idx,
    output logic             wrap
);

    localparam int unsigned W       = 2 ** N;
    localparam int unsigned DW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N-1:0] IDX_MAX = {N{1'b1}};
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [N-1:0]  idx_nxt;
    logic [W-1:0]  d_nxt;
    logic          wrap_nxt;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dwell <= '0;
            idx   <= '0;
            d     <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            dwell <= dwell_nxt;
            idx   <= idx_nxt;
            d     <= d_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Next state follows en/mode every cycle; register values follow the next state
    always_comb begin
        state_nxt = IDLE;
        dwell_nxt = '0;
        idx_nxt   = idx;
        d_nxt     = '0;
        wrap_nxt  = 1'b0;

        if (en) begin
            state_nxt = mode ? SCAN : DIRECT;
        end

        case (state_nxt)
            DIRECT: begin
                idx_nxt = i;
                d_nxt   = W'(1) << i;
            end
            SCAN: begin
                if (state != SCAN) begin
                    // Fresh entry always restarts at index 0
                    idx_nxt = '0;
                end else if (load) begin
                    idx_nxt = i;
                end else if (dwell == DWELL_LAST) begin
                    idx_nxt  = idx + N'(1);
                    wrap_nxt = (idx == IDX_MAX);
                end else begin
                    dwell_nxt = dwell + DW'(1);
                end
                d_nxt = W'(1) << idx_nxt;
            end
            default: begin
                idx_nxt = idx;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_nx_scan.sv
// Directed bench for decoder_nx_scan: one instance at N=2/DWELL=4, one at N=3/DWELL=1.
module tb_decoder_nx_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       en_a = 1'b0, mode_a = 1'b0, load_a = 1'b0;
    logic [1:0] i_a = '0;
    logic [3:0] d_a;
    logic [1:0] idx_a;
    logic       wrap_a;

    logic       en_b = 1'b0, mode_b = 1'b0, load_b = 1'b0;
    logic [2:0] i_b = '0;
    logic [7:0] d_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_nx_scan #(.N(2), .DWELL(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .i(i_a),
        .load(load_a), .d(d_a), .idx(idx_a), .wrap(wrap_a)
    );

    decoder_nx_scan #(.N(3), .DWELL(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .i(i_b),
        .load(load_b), .d(d_b), .idx(idx_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all three outputs of instance A
    task automatic check_a(input string tag, input int e_idx, input logic e_wrap);
        check({tag, ".idx"}, 32'(idx_a), 32'(e_idx));
        check({tag, ".d"}, 32'(d_a), 32'(4'b0001 << e_idx));
        check({tag, ".wrap"}, 32'(wrap_a), 32'(e_wrap));
    endtask

    initial begin
        // Reset at time 1, well away from any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst.d_a", 32'(d_a), 32'h0);
        check("rst.idx_a", 32'(idx_a), 32'h0);
        check("rst.wrap_a", 32'(wrap_a), 32'h0);
        check("rst.d_b", 32'(d_b), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle.d_a", 32'(d_a), 32'h0);

        // Direct decode of 0..3, latency 1
        en_a = 1'b1; mode_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_a = 2'(k);
            tick();
            check("direct.d", 32'(d_a), 32'(4'b0001 << k));
            check("direct.idx", 32'(idx_a), 32'(k));
            check("direct.wrap", 32'(wrap_a), 32'h0);
        end
        // load has no effect in direct mode
        load_a = 1'b1; i_a = 2'd2;
        tick();
        check("direct_load.d", 32'(d_a), 32'h4);
        load_a = 1'b0;

        // Scan: each index held 4 cycles, wrap once when 3 -> 0
        mode_a = 1'b1;
        for (int k = 0; k < 21; k++) begin
            tick();
            check_a("scan", (k / 4) % 4, (k == 16));
        end
        // Now idx=1 with dwell=0; load 3
        load_a = 1'b1; i_a = 2'd3;
        tick();
        check_a("load", 3, 1'b0);
        load_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_a("load_hold", 3, 1'b0);
        end
        tick();
        check_a("load_wrap", 0, 1'b1);

        // Load on the same edge as an advance: i wins over idx+1
        tick(); tick(); tick();
        check_a("pre_coinc", 0, 1'b0);
        load_a = 1'b1; i_a = 2'd2;
        tick();
        check_a("coinc_load", 2, 1'b0);
        load_a = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check_a("pre_load_nowrap", 3, 1'b0);
        load_a = 1'b1; i_a = 2'd0;
        tick();
        check_a("load_nowrap", 0, 1'b0);
        load_a = 1'b0;

        // SCAN -> DIRECT mid-dwell, then back into SCAN from 0
        tick();
        mode_a = 1'b0; i_a = 2'd1;
        tick();
        check_a("scan2direct", 1, 1'b0);
        mode_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_a("rescan", 0, 1'b0);
        end
        tick();
        check_a("rescan_adv", 1, 1'b0);

        // en low: d cleared, idx held; re-enable restarts at 0
        en_a = 1'b0;
        tick();
        check("en_off.d", 32'(d_a), 32'h0);
        check("en_off.idx", 32'(idx_a), 32'h1);
        check("en_off.wrap", 32'(wrap_a), 32'h0);
        tick();
        check("en_off2.idx", 32'(idx_a), 32'h1);
        en_a = 1'b1;
        tick();
        check_a("en_on", 0, 1'b0);

        // Async reset between edges while d=0100
        mode_a = 1'b0; i_a = 2'd2;
        tick();
        check("pre_arst.d", 32'(d_a), 32'h4);
        mode_a = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst.d", 32'(d_a), 32'h0);
        check("arst.idx", 32'(idx_a), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        check_a("post_arst", 0, 1'b0);
        en_a = 1'b0;

        // N=3, DWELL=1: index advances every cycle, wrap every 8th cycle
        en_b = 1'b1; mode_b = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            check("b.idx", 32'(idx_b), 32'(k % 8));
            check("b.d", 32'(d_b), 32'(8'b0000_0001 << (k % 8)));
            check("b.onehot", 32'($onehot(d_b)), 32'h1);
            check("b.wrap", 32'(wrap_b), 32'((k == 8) || (k == 16)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
